// File: rtl/rmii_tx_pkg.sv
// Shared types and constants for the RMII transmit frame sequencer.
package rmii_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    // One byte step of the reflected IEEE 802.3 CRC-32, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/rmii_crc32.sv
// Byte-wide CRC-32 register: CLEAR reloads the seed, ENABLE folds in DATA.
module rmii_crc32
    import rmii_tx_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CLEAR,
    input  logic        ENABLE,
    input  logic [7:0]  DATA,
    output logic [31:0] CRC
);

    // CRC accumulator; CLEAR wins over ENABLE.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the netlist.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            CRC <= CRC_INIT;
        end else if (CLEAR) begin
            CRC <= CRC_INIT;
        end else if (ENABLE) begin
            CRC <= crc32_byte(CRC, DATA);
        end
    end

endmodule

// File: rtl/rmii_tx_frame_ctrl.sv
// Transmit frame sequencer: preamble, SFD, payload, pad, FCS and inter-frame
// gap, delivered as an unbroken byte stream to the RMII serializer.
module rmii_tx_frame_ctrl
    import rmii_tx_pkg::*;
#(
    parameter int PREAMBLE_BYTES  = 7,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int IFG_BYTES       = 12
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic [7:0] S_AXIS_TDATA,
    input  logic       S_AXIS_TVALID,
    input  logic       S_AXIS_TLAST,
    output logic       S_AXIS_TREADY,
    output logic [7:0] M_AXIS_TDATA,
    output logic       M_AXIS_TVALID,
    input  logic       M_AXIS_TREADY,
    output logic       BUSY,
    output logic       FRAME_DONE,
    output logic       UNDERRUN
);

    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES - 1);
    localparam logic [15:0] MIN_CNT  = 16'(MIN_FRAME_BYTES);
    localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES * 4 - 1);

    tx_state_e   state, state_nxt;
    logic        m_valid, hs, fetch_phase, fetch, underrun, start_ok;
    logic [7:0]  idx_cnt;      // byte index inside PREAMBLE / FCS
    logic [15:0] byte_cnt;     // payload + pad bytes sent, saturating
    logic [15:0] byte_cnt_inc;
    logic [15:0] ifg_cnt;
    logic [7:0]  cur_byte;
    logic        cur_last;
    logic        bad_fcs, discard;
    logic        frame_done_q, underrun_q;
    logic [31:0] crc, fcs_word;
    logic [7:0]  fcs_byte, tx_byte;
    logic        crc_clr, crc_en;

    assign m_valid      = (state != ST_IDLE) && (state != ST_IFG);
    assign hs           = m_valid & M_AXIS_TREADY;
    assign fetch_phase  = (state == ST_SFD) || ((state == ST_DATA) && !cur_last);
    // Combinational ready: a payload byte is only taken in a serializer hs cycle,
    // except while draining the rest of an underrun packet.
    assign S_AXIS_TREADY = discard | (M_AXIS_TREADY & fetch_phase);
    assign start_ok     = ENABLE & S_AXIS_TVALID & ~discard;
    assign byte_cnt_inc = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
    // A truncated frame carries the raw register, which can never check good.
    assign fcs_word     = bad_fcs ? crc : ~crc;

    assign M_AXIS_TDATA  = tx_byte;
    assign M_AXIS_TVALID = m_valid;
    assign BUSY          = (state != ST_IDLE);
    assign FRAME_DONE    = frame_done_q;
    assign UNDERRUN      = underrun_q;

    // FCS byte select, least significant byte first.
    always_comb begin
        fcs_byte = fcs_word[7:0];
        case (idx_cnt[1:0])
            2'd1:    fcs_byte = fcs_word[15:8];
            2'd2:    fcs_byte = fcs_word[23:16];
            2'd3:    fcs_byte = fcs_word[31:24];
            default: fcs_byte = fcs_word[7:0];
        endcase
    end

    // Next-state, outgoing byte and payload fetch decisions.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        tx_byte   = 8'h00;
        fetch     = 1'b0;
        underrun  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) state_nxt = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                tx_byte = PREAMBLE_BYTE;
                if (hs && (idx_cnt == PRE_LAST)) state_nxt = ST_SFD;
            end
            ST_SFD: begin
                tx_byte = SFD_BYTE;
                if (hs) begin
                    fetch = 1'b1;
                    if (S_AXIS_TVALID) begin
                        state_nxt = ST_DATA;
                    end else begin
                        underrun  = 1'b1;
                        state_nxt = ST_FCS;
                    end
                end
            end
            ST_DATA: begin
                tx_byte = cur_byte;
                if (hs) begin
                    if (cur_last) begin
                        state_nxt = (byte_cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
                    end else begin
                        fetch = 1'b1;
                        if (!S_AXIS_TVALID) begin
                            underrun  = 1'b1;
                            state_nxt = ST_FCS;
                        end
                    end
                end
            end
            ST_PAD: begin
                tx_byte = 8'h00;
                if (hs && (byte_cnt_inc >= MIN_CNT)) state_nxt = ST_FCS;
            end
            ST_FCS: begin
                tx_byte = fcs_byte;
                if (hs && (idx_cnt[1:0] == 2'd3)) state_nxt = ST_IFG;
            end
            ST_IFG: begin
                // Leaving straight for PREAMBLE keeps back-to-back frames exactly
                // IFG_BYTES byte times apart and on the serializer's byte phase.
                if (ifg_cnt == 16'd0) state_nxt = start_ok ? ST_PREAMBLE : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Frame counters: byte index, payload+pad count and gap timer.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            idx_cnt  <= 8'd0;
            byte_cnt <= 16'd0;
            ifg_cnt  <= IFG_LAST;
        end else begin
            if (state_nxt != state) idx_cnt <= 8'd0;
            else if (hs)            idx_cnt <= idx_cnt + 8'd1;

            if (state == ST_PREAMBLE)                               byte_cnt <= 16'd0;
            else if (hs && ((state == ST_DATA) || (state == ST_PAD))) byte_cnt <= byte_cnt_inc;

            // Held at full length outside IFG so each IFG entry restarts it.
            if (state != ST_IFG)      ifg_cnt <= IFG_LAST;
            else if (ifg_cnt != 16'd0) ifg_cnt <= ifg_cnt - 16'd1;
        end
    end

    // Payload holding byte, underrun/discard flags and status pulses.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cur_byte     <= 8'h00;
            cur_last     <= 1'b0;
            bad_fcs      <= 1'b0;
            discard      <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            if (fetch && S_AXIS_TVALID) begin
                cur_byte <= S_AXIS_TDATA;
                cur_last <= S_AXIS_TLAST;
            end

            if (state == ST_PREAMBLE) bad_fcs <= 1'b0;
            else if (underrun)        bad_fcs <= 1'b1;

            if (underrun)                                     discard <= 1'b1;
            else if (discard && S_AXIS_TVALID && S_AXIS_TLAST) discard <= 1'b0;

            frame_done_q <= (state == ST_FCS) && (state_nxt == ST_IFG);
            underrun_q   <= underrun;
        end
    end

    rmii_crc32 u_crc (
        .CLK    (CLK),
        .RESET  (RESET),
        .CLEAR  (crc_clr),
        .ENABLE (crc_en),
        .DATA   (tx_byte),
        .CRC    (crc)
    );

    assign crc_clr = (state == ST_PREAMBLE);
    assign crc_en  = hs && ((state == ST_DATA) || (state == ST_PAD));

endmodule
